fight_referee: RTL and testbench

Match sequencer for the two-player fighting game. Collects one action per player per turn over a valid/ready handshake, substitutes `wait` on timeout, and issues a single commit pulse to both player blocks. After each turn it reads back their health, decides the round, and counts round wins until a match winner or draw is declared.

---
 rtl/fight_pkg.sv | 33 +++
 rtl/fight_referee_action_latch.sv | 53 +++++
 rtl/fight_referee.sv | 183 ++++++++++++++++++
 tb/tb_fight_referee.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fight_pkg.sv
// Shared definitions for the fight referee: action codes, winner codes,
// referee states and the illegal-code-to-wait substitution.
package fight_pkg;

    localparam logic [2:0] ACT_KICK  = 3'b000;
    localparam logic [2:0] ACT_PUNCH = 3'b001;
    localparam logic [2:0] ACT_WAIT  = 3'b010;
    localparam logic [2:0] ACT_JUMP  = 3'b011;
    localparam logic [2:0] ACT_LEFT  = 3'b100;
    localparam logic [2:0] ACT_RIGHT = 3'b101;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROUND_INIT,
        ST_COLLECT,
        ST_COMMIT,
        ST_SETTLE,
        ST_CHECK,
        ST_ROUND_END,
        ST_MATCH_END
    } state_t;

    // Codes 110 and 111 have no meaning in the game and are played as wait.
    function automatic logic [2:0] sanitize_action(input logic [2:0] code);
        return (code >= 3'b110) ? ACT_WAIT : code;
    endfunction

endpackage

// File: rtl/fight_referee_action_latch.sv
// Per-player action handshake: accepts one action per turn while collect is
// high and presents the action to commit (held, just accepted, or wait).
module action_latch
    import fight_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       collect,
    input  logic       act_valid,
    input  logic [2:0] act,
    output logic       act_ready,
    output logic       done,
    output logic [2:0] action
);

    logic       latched_q, latched_d;
    logic [2:0] hold_q, hold_d;
    logic       accept;

    always_comb begin
        act_ready = collect & ~latched_q;
        accept    = act_valid & act_ready;
        latched_d = latched_q;
        hold_d    = hold_q;
        if (!collect) begin
            latched_d = 1'b0;
            hold_d    = ACT_WAIT;
        end else if (accept) begin
            latched_d = 1'b1;
            hold_d    = sanitize_action(act);
        end
        // An offer in the final collect cycle must still reach the commit.
        done = latched_q | accept;
        if (latched_q) begin
            action = hold_q;
        end else if (accept) begin
            action = sanitize_action(act);
        end else begin
            action = ACT_WAIT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latched_q <= 1'b0;
            hold_q    <= ACT_WAIT;
        end else begin
            latched_q <= latched_d;
            hold_q    <= hold_d;
        end
    end

endmodule

// File: rtl/fight_referee.sv
// Match sequencer for the two-player fighting game. Define TURN_LIMIT_EN to
// force a round decision by health after MAX_TURNS turns.
module fight_referee
    import fight_pkg::*;
#(
    parameter int unsigned TURN_TIMEOUT  = 15,
    parameter int unsigned ROUNDS_TO_WIN = 2,
    parameter int unsigned MAX_TURNS     = 31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       act1_valid,
    input  logic [2:0] act1,
    output logic       act1_ready,
    input  logic       act2_valid,
    input  logic [2:0] act2,
    output logic       act2_ready,
    output logic [2:0] turn_action1,
    output logic [2:0] turn_action2,
    output logic       turn_commit,
    output logic       round_reset,
    input  logic [1:0] health1,
    input  logic [1:0] health2,
    output logic [1:0] wins1,
    output logic [1:0] wins2,
    output logic       round_over,
    output logic       match_over,
    output logic [1:0] winner,
    output logic       busy
);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [1:0] wins1_q, wins1_d, wins2_q, wins2_d;
    logic [2:0] rounds_q, rounds_d;
    logic [1:0] result_q, result_d;
    logic [2:0] act1_q, act1_d, act2_q, act2_d;
`ifdef TURN_LIMIT_EN
    logic [7:0] turn_q, turn_d;
`endif

    logic       collect;
    logic       done1, done2;
    logic [2:0] action1, action2;

    assign collect = (state_q == ST_COLLECT);

    action_latch u_latch1 (
        .clk(clk), .rst(rst), .collect(collect), .act_valid(act1_valid), .act(act1),
        .act_ready(act1_ready), .done(done1), .action(action1)
    );

    action_latch u_latch2 (
        .clk(clk), .rst(rst), .collect(collect), .act_valid(act2_valid), .act(act2),
        .act_ready(act2_ready), .done(done2), .action(action2)
    );

    always_comb begin
        state_d  = state_q;
        timer_d  = '0;
        wins1_d  = wins1_q;
        wins2_d  = wins2_q;
        rounds_d = rounds_q;
        result_d = result_q;
        act1_d   = act1_q;
        act2_d   = act2_q;
`ifdef TURN_LIMIT_EN
        turn_d   = turn_q;
`endif
        case (state_q)
            ST_IDLE, ST_MATCH_END: begin
                if (start) begin
                    wins1_d  = '0;
                    wins2_d  = '0;
                    rounds_d = '0;
                    state_d  = ST_ROUND_INIT;
                end
            end
            ST_ROUND_INIT: begin
`ifdef TURN_LIMIT_EN
                turn_d  = '0;
`endif
                state_d = ST_COLLECT;
            end
            ST_COLLECT: begin
                timer_d = timer_q + 8'd1;
                if ((done1 && done2) || (timer_q == 8'(TURN_TIMEOUT - 1))) begin
                    act1_d  = action1;
                    act2_d  = action2;
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_CHECK;
            ST_CHECK: begin
                if (health1 == 2'd0 && health2 == 2'd0) begin
                    result_d = WIN_DRAW;
                    state_d  = ST_ROUND_END;
                end else if (health1 == 2'd0) begin
                    result_d = WIN_P2;
                    state_d  = ST_ROUND_END;
                end else if (health2 == 2'd0) begin
                    result_d = WIN_P1;
                    state_d  = ST_ROUND_END;
                end else begin
`ifdef TURN_LIMIT_EN
                    if (turn_q == 8'(MAX_TURNS - 1)) begin
                        if (health1 > health2)      result_d = WIN_P1;
                        else if (health2 > health1) result_d = WIN_P2;
                        else                        result_d = WIN_DRAW;
                        state_d = ST_ROUND_END;
                    end else begin
                        turn_d  = turn_q + 8'd1;
                        state_d = ST_COLLECT;
                    end
`else
                    state_d = ST_COLLECT;
`endif
                end
            end
            ST_ROUND_END: begin
                if (result_q == WIN_P1) wins1_d = wins1_q + 2'd1;
                if (result_q == WIN_P2) wins2_d = wins2_q + 2'd1;
                rounds_d = rounds_q + 3'd1;
                if (wins1_d == 2'(ROUNDS_TO_WIN) || wins2_d == 2'(ROUNDS_TO_WIN) ||
                    rounds_d == 3'(2 * ROUNDS_TO_WIN - 1)) begin
                    state_d = ST_MATCH_END;
                end else begin
                    state_d = ST_ROUND_INIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            wins1_q  <= '0;
            wins2_q  <= '0;
            rounds_q <= '0;
            result_q <= WIN_NONE;
            act1_q   <= ACT_WAIT;
            act2_q   <= ACT_WAIT;
`ifdef TURN_LIMIT_EN
            turn_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            wins1_q  <= wins1_d;
            wins2_q  <= wins2_d;
            rounds_q <= rounds_d;
            result_q <= result_d;
            act1_q   <= act1_d;
            act2_q   <= act2_d;
`ifdef TURN_LIMIT_EN
            turn_q   <= turn_d;
`endif
        end
    end

    always_comb begin
        turn_action1 = act1_q;
        turn_action2 = act2_q;
        turn_commit  = (state_q == ST_COMMIT);
        round_reset  = (state_q == ST_ROUND_INIT);
        round_over   = (state_q == ST_ROUND_END);
        match_over   = (state_q == ST_MATCH_END);
        busy         = (state_q != ST_IDLE) && (state_q != ST_MATCH_END);
        wins1        = wins1_q;
        wins2        = wins2_q;
        winner       = WIN_NONE;
        if (state_q == ST_MATCH_END) begin
            if (wins1_q > wins2_q)      winner = WIN_P1;
            else if (wins2_q > wins1_q) winner = WIN_P2;
            else                        winner = WIN_DRAW;
        end
    end

endmodule

// File: tb/tb_fight_referee.sv
// Self-checking bench for fight_referee: table-driven turns with a commit
// scoreboard, plus hand-written timeout, handshake and reset sequences.
module tb_fight_referee;
    import fight_pkg::*;

    typedef struct {
        logic       v1;
        logic [2:0] a1;
        logic       v2;
        logic [2:0] a2;
        logic [1:0] h1;
        logic [1:0] h2;
        logic [2:0] e1;
        logic [2:0] e2;
        int         lat;
        logic       e_ro;
        logic [1:0] e_w1;
        logic [1:0] e_w2;
        logic       e_mo;
        logic [1:0] e_win;
    } vec_t;

    typedef struct {
        logic [2:0] a1;
        logic [2:0] a2;
    } exp_turn_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       act1_valid, act2_valid;
    logic [2:0] act1, act2;
    logic       act1_ready, act2_ready;
    logic [2:0] turn_action1, turn_action2;
    logic       turn_commit, round_reset, round_over, match_over, busy;
    logic [1:0] health1, health2, wins1, wins2, winner;

    int n_cmp = 0;
    int n_bad = 0;
    exp_turn_t sb[$];
    vec_t vecs[7];
`ifdef TURN_LIMIT_EN
    vec_t lim_vecs[3];
`endif

    fight_referee #(.TURN_TIMEOUT(15), .ROUNDS_TO_WIN(2), .MAX_TURNS(3)) dut (
        .clk(clk), .rst(rst), .start(start),
        .act1_valid(act1_valid), .act1(act1), .act1_ready(act1_ready),
        .act2_valid(act2_valid), .act2(act2), .act2_ready(act2_ready),
        .turn_action1(turn_action1), .turn_action2(turn_action2),
        .turn_commit(turn_commit), .round_reset(round_reset),
        .health1(health1), .health2(health2),
        .wins1(wins1), .wins2(wins2), .round_over(round_over),
        .match_over(match_over), .winner(winner), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard: every observed commit must match the oldest expected turn.
    always @(negedge clk) begin
        if (!rst && turn_commit) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_commit", 32'd1, 32'd0);
            end else begin
                exp_turn_t e;
                e = sb.pop_front();
                checkOutput("turn_action1", 32'(turn_action1), 32'(e.a1));
                checkOutput("turn_action2", 32'(turn_action2), 32'(e.a2));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        $display("[TB] reset output check: %s", tag);
        checkOutput("rst_act1_ready", 32'(act1_ready), 32'd0);
        checkOutput("rst_act2_ready", 32'(act2_ready), 32'd0);
        checkOutput("rst_turn_action1", 32'(turn_action1), 32'(ACT_WAIT));
        checkOutput("rst_turn_action2", 32'(turn_action2), 32'(ACT_WAIT));
        checkOutput("rst_turn_commit", 32'(turn_commit), 32'd0);
        checkOutput("rst_round_reset", 32'(round_reset), 32'd0);
        checkOutput("rst_wins1", 32'(wins1), 32'd0);
        checkOutput("rst_wins2", 32'(wins2), 32'd0);
        checkOutput("rst_round_over", 32'(round_over), 32'd0);
        checkOutput("rst_match_over", 32'(match_over), 32'd0);
        checkOutput("rst_winner", 32'(winner), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_round_reset", 32'(round_reset), 32'd1);
        checkOutput("start_busy", 32'(busy), 32'd1);
    endtask

    // Returns at the negedge where both ready flags show a fresh COLLECT.
    task automatic wait_collect();
        for (int k = 0; k < 60; k++) begin
            if (act1_ready && act2_ready) return;
            @(negedge clk);
        end
        checkOutput("collect_wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_commit(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                act1_valid = 1'b0;
                act2_valid = 1'b0;
            end
            if (turn_commit) begin
                lat = k;
                return;
            end
        end
        checkOutput("commit_wait_timeout", 32'd0, 32'd1);
    endtask

    // Called at the commit negedge; SETTLE and CHECK follow, then ROUND_END or COLLECT.
    task automatic check_round(input logic e_ro, input logic [1:0] e_w1, input logic [1:0] e_w2,
                               input logic e_mo, input logic [1:0] e_win);
        repeat (3) @(negedge clk);
        checkOutput("round_over", 32'(round_over), 32'(e_ro));
        if (e_ro) begin
            @(negedge clk);
            checkOutput("wins1", 32'(wins1), 32'(e_w1));
            checkOutput("wins2", 32'(wins2), 32'(e_w2));
            checkOutput("match_over", 32'(match_over), 32'(e_mo));
            checkOutput("winner", 32'(winner), 32'(e_win));
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int lat;
        exp_turn_t e;
        wait_collect();
        act1_valid = v.v1;
        act1       = v.a1;
        act2_valid = v.v2;
        act2       = v.a2;
        health1    = v.h1;
        health2    = v.h2;
        e.a1 = v.e1;
        e.a2 = v.e2;
        sb.push_back(e);
        wait_commit(lat);
        checkOutput("commit_latency", 32'(lat), 32'(v.lat));
        check_round(v.e_ro, v.e_w1, v.e_w2, v.e_mo, v.e_win);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_turn_t e;
        //            v1    a1         v2    a2         h1    h2    e1         e2         lat ro    w1    w2    mo    win
        vecs[0] = '{1'b1, ACT_KICK,  1'b1, ACT_PUNCH, 2'd3, 2'd3, ACT_KICK,  ACT_PUNCH, 1,  1'b0, 2'd0, 2'd0, 1'b0, WIN_NONE};
        vecs[1] = '{1'b1, ACT_JUMP,  1'b0, ACT_KICK,  2'd3, 2'd3, ACT_JUMP,  ACT_WAIT,  15, 1'b0, 2'd0, 2'd0, 1'b0, WIN_NONE};
        vecs[2] = '{1'b1, ACT_LEFT,  1'b1, 3'b111,    2'd2, 2'd0, ACT_LEFT,  ACT_WAIT,  1,  1'b1, 2'd1, 2'd0, 1'b0, WIN_NONE};
        vecs[3] = '{1'b1, 3'b110,    1'b1, ACT_KICK,  2'd3, 2'd0, ACT_WAIT,  ACT_KICK,  1,  1'b1, 2'd2, 2'd0, 1'b1, WIN_P1};
        vecs[4] = '{1'b1, ACT_RIGHT, 1'b1, ACT_JUMP,  2'd0, 2'd0, ACT_RIGHT, ACT_JUMP,  1,  1'b1, 2'd0, 2'd0, 1'b0, WIN_NONE};
        vecs[5] = '{1'b1, ACT_PUNCH, 1'b1, ACT_PUNCH, 2'd0, 2'd0, ACT_PUNCH, ACT_PUNCH, 1,  1'b1, 2'd0, 2'd0, 1'b0, WIN_NONE};
        vecs[6] = '{1'b1, ACT_WAIT,  1'b1, ACT_LEFT,  2'd0, 2'd0, ACT_WAIT,  ACT_LEFT,  1,  1'b1, 2'd0, 2'd0, 1'b1, WIN_DRAW};
`ifdef TURN_LIMIT_EN
        lim_vecs[0] = '{1'b1, ACT_KICK, 1'b1, ACT_KICK, 2'd3, 2'd2, ACT_KICK, ACT_KICK, 1, 1'b0, 2'd0, 2'd0, 1'b0, WIN_NONE};
        lim_vecs[1] = lim_vecs[0];
        lim_vecs[2] = '{1'b1, ACT_KICK, 1'b1, ACT_KICK, 2'd3, 2'd2, ACT_KICK, ACT_KICK, 1, 1'b1, 2'd1, 2'd0, 1'b0, WIN_NONE};
`endif

        rst = 1'b1;
        start = 1'b0;
        act1_valid = 1'b0;
        act2_valid = 1'b0;
        act1 = ACT_WAIT;
        act2 = ACT_WAIT;
        health1 = 2'd3;
        health2 = 2'd3;
        repeat (2) @(negedge clk);
        check_reset_outputs("power-on");
        rst = 1'b0;
        @(negedge clk);

        // Match 1 (player 1 wins 2-0) and match 2 (three draws).
        for (int i = 0; i < 7; i++) begin
            if (i == 0 || i == 4) do_start();
            applyStimulus(vecs[i]);
        end

        // Match 3: staggered handshake and an offer landing on the timeout cycle.
        do_start();
        wait_collect();
        act2_valid = 1'b1;
        act2       = ACT_PUNCH;
        health1    = 2'd3;
        health2    = 2'd0;
        @(negedge clk);
        checkOutput("ready2_drops_after_accept", 32'(act2_ready), 32'd0);
        checkOutput("ready1_still_high", 32'(act1_ready), 32'd1);
        act2_valid = 1'b0;
        repeat (13) @(negedge clk);
        act1_valid = 1'b1;
        act1       = ACT_RIGHT;
        e.a1 = ACT_RIGHT;
        e.a2 = ACT_PUNCH;
        sb.push_back(e);
        @(negedge clk);
        act1_valid = 1'b0;
        checkOutput("timeout_accept_commit", 32'(turn_commit), 32'd1);
        check_round(1'b1, 2'd1, 2'd0, 1'b0, WIN_NONE);

        // Round 2 of match 3: asynchronous reset in the middle of COLLECT.
        wait_collect();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid-match");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("post_rst_busy", 32'(busy), 32'd0);
        checkOutput("post_rst_round_reset", 32'(round_reset), 32'd0);
        checkOutput("post_rst_ready1", 32'(act1_ready), 32'd0);

`ifdef TURN_LIMIT_EN
        do_start();
        for (int i = 0; i < 3; i++) applyStimulus(lim_vecs[i]);
`endif

        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
